// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared widths, payload bundle and skid-buffer states for the EX/MEM stage
//   DATA_W, REG_ADDR_W : datapath and register-address widths
//   ex_mem_payload_t   : bundle captured from EX (control bits occupy the four LSBs)
//   CTRL_MASK          : payload bits cleared by a flush (the MEM/WB control bits)
//   state_t            : EMPTY (0 held), FULL (main held), SKID (main + skid held)
package ex_mem_pkg;
   localparam int DATA_W = 32;
   localparam int REG_ADDR_W = 5;
   typedef struct packed {
      logic [DATA_W-1:0]     alu_result;
      logic                  zero;
      logic [DATA_W-1:0]     store_data;
      logic [REG_ADDR_W-1:0] rd_addr;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  mem_to_reg;
   } ex_mem_payload_t;
   localparam int PAYLOAD_W = $bits(ex_mem_payload_t);
   localparam logic [PAYLOAD_W-1:0] CTRL_MASK = PAYLOAD_W'(4'hF);
   typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
endpackage

// File: rtl/ex_mem_skid_buffer.sv
// skid_buffer: generic 2-entry valid/ready skid buffer with synchronous flush
//   clk_i, rst_i (async, active-low), flush_i
//   valid_i/ready_o/data_i : upstream handshake; ready_o depends on state only
//   valid_o/ready_i/data_o : downstream handshake; data_o always comes from main
//   occupancy_o            : entries held (0..2)
//   CLR_MASK               : bits of both entries zeroed on flush, others hold
module skid_buffer
   import ex_mem_pkg::*;
#(
   parameter int W = 8,
   parameter logic [W-1:0] CLR_MASK = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] data_o,
   output logic [1:0]   occupancy_o
);
   state_t r_state, w_next;
   logic [W-1:0] r_main, r_skid;
   logic w_in, w_out;
   assign valid_o = r_state != EMPTY;
   // rst_i gates ready so it is low while reset is held and rises on release
   assign ready_o = rst_i & (r_state != SKID);
   assign occupancy_o = (r_state == SKID) ? 2'd2 : (r_state == FULL) ? 2'd1 : 2'd0;
   assign data_o = r_main;
   assign w_in = valid_i & ready_o;
   assign w_out = valid_o & ready_i;
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= EMPTY;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         EMPTY: if (w_in) w_next = FULL;
         FULL: if (w_in && !w_out) w_next = SKID;
               else if (!w_in && w_out) w_next = EMPTY;
         SKID: if (w_out) w_next = FULL;
         default: w_next = EMPTY;
      endcase
      if (flush_i) w_next = EMPTY;
   end
   // w_in implies state != SKID, so main takes the input when empty or draining in lockstep
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_main <= '0;
         r_skid <= '0;
      end else if (flush_i) begin
         r_main <= r_main & ~CLR_MASK;
         r_skid <= r_skid & ~CLR_MASK;
      end else begin
         if (r_state == SKID && w_out) r_main <= r_skid;
         else if (w_in && (r_state == EMPTY || w_out)) r_main <= data_i;
         if (w_in && r_state == FULL && !w_out) r_skid <= data_i;
      end
   end
endmodule

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: EX/MEM pipeline register with a 2-entry skid buffer toward the MEM stage
//   clk_i, rst_i (async, active-low), flush_i (sync, turns held entries into bubbles)
//   valid_i/ready_o + ALU bundle inputs from EX
//   valid_o/ready_i + registered bundle outputs toward MEM, occupancy_o (0..2)
//   Widths DATA_W and REG_ADDR_W come from ex_mem_pkg.
module ex_mem_skid
   import ex_mem_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_W-1:0]     alu_result_i,
   input  logic                  zero_i,
   input  logic [DATA_W-1:0]     store_data_i,
   input  logic [REG_ADDR_W-1:0] rd_addr_i,
   input  logic                  reg_write_i,
   input  logic                  mem_read_i,
   input  logic                  mem_write_i,
   input  logic                  mem_to_reg_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_W-1:0]     alu_result_o,
   output logic                  zero_o,
   output logic [DATA_W-1:0]     store_data_o,
   output logic [REG_ADDR_W-1:0] rd_addr_o,
   output logic                  reg_write_o,
   output logic                  mem_read_o,
   output logic                  mem_write_o,
   output logic                  mem_to_reg_o,
   output logic [1:0]            occupancy_o
);
   ex_mem_payload_t w_in_p, w_out_p;
   assign w_in_p = {alu_result_i, zero_i, store_data_i, rd_addr_i,
                    reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i};
   skid_buffer #(.W(PAYLOAD_W), .CLR_MASK(CTRL_MASK)) u_skid (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .flush_i(flush_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .data_i(w_in_p),
      .valid_o(valid_o),
      .ready_i(ready_i),
      .data_o(w_out_p),
      .occupancy_o(occupancy_o)
   );
   assign alu_result_o = w_out_p.alu_result;
   assign zero_o = w_out_p.zero;
   assign store_data_o = w_out_p.store_data;
   assign rd_addr_o = w_out_p.rd_addr;
   assign reg_write_o = w_out_p.reg_write;
   assign mem_read_o = w_out_p.mem_read;
   assign mem_write_o = w_out_p.mem_write;
   assign mem_to_reg_o = w_out_p.mem_to_reg;
endmodule
